// File: rtl/cv32e40s_pkg.sv
// Shared types and constants for the dummy-instruction LFSR scheduler.
// Imported by cv32e40s_lfsr_step and cv32e40s_lfsr_sched.
package cv32e40s_pkg;

  typedef enum logic [1:0] {
    OFF = 2'd0,
    ARM = 2'd1,
    RUN = 2'd2
  } lfsr_sched_state_e;

  localparam logic [31:0] LFSR_SEED_DEFAULT = 32'h2A5C_9E13;
  localparam logic [31:0] LFSR_TAPS_DEFAULT = 32'h8020_0003;

  localparam int unsigned CPUCTRL_RNDDUMMY_BIT = 0;
  localparam int unsigned CPUCTRL_FREQ_LSB     = 1;
  localparam int unsigned CPUCTRL_FREQ_MSB     = 4;

endpackage

// File: rtl/cv32e40s_lfsr_step.sv
// Galois LFSR next-state with load, step and zero-state recovery.
// Purely combinational; reusable for further LFSR instances.
module cv32e40s_lfsr_step
  import cv32e40s_pkg::*;
#(
  parameter logic [31:0] TAPS = LFSR_TAPS_DEFAULT,
  parameter logic [31:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic [31:0] lfsr_i,
  input  logic        step_i,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  output logic [31:0] next_o,
  output logic        lockup_o
);

  logic [31:0] stepped;
  logic [31:0] cand;

  // Load beats step; an all-zero result is replaced by the seed
  always_comb begin
    stepped  = {1'b0, lfsr_i[31:1]} ^ (lfsr_i[0] ? TAPS : 32'h0);
    cand     = lfsr_i;
    if (load_i) begin
      cand = load_val_i;
    end else if (step_i) begin
      cand = stepped;
    end
    lockup_o = (cand == 32'h0);
    next_o   = lockup_o ? SEED : cand;
  end

endmodule

// File: rtl/cv32e40s_lfsr_sched.sv
// Dummy-instruction LFSR owner and enable/counter-reset sequencer.
// CV32E40S_LFSR_LOCKUP_CNT_EN adds a saturating lockup counter.
module cv32e40s_lfsr_sched
  import cv32e40s_pkg::*;
#(
  parameter logic [31:0] LFSR_SEED = LFSR_SEED_DEFAULT,
  parameter logic [31:0] LFSR_TAPS = LFSR_TAPS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_we_i,
  input  logic [31:0] seed_wdata_i,
  input  logic        cpuctrl_we_i,
  input  logic [4:0]  cpuctrl_wdata_i,
  input  logic        shift_i,
  output logic [31:0] lfsr_o,
  output logic        rnddummy_o,
  output logic [3:0]  rnddummyfreq_o,
  output logic        cntrst_o,
`ifdef CV32E40S_LFSR_LOCKUP_CNT_EN
  output logic [7:0]  lockup_cnt_o,
`endif
  output logic        lockup_o
);

  lfsr_sched_state_e state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [3:0]  freq_q, freq_d;
  logic        rnd_q, cntrst_q, cntrst_d;
  logic        lockup_q, lockup_d;
  logic        step_en;
  logic        wr_en;
  logic [3:0]  wr_freq;

  assign wr_en   = cpuctrl_wdata_i[CPUCTRL_RNDDUMMY_BIT];
  assign wr_freq = cpuctrl_wdata_i[CPUCTRL_FREQ_MSB:CPUCTRL_FREQ_LSB];

  cv32e40s_lfsr_step #(
    .TAPS (LFSR_TAPS),
    .SEED (LFSR_SEED)
  ) u_step (
    .lfsr_i     (lfsr_q),
    .step_i     (step_en),
    .load_i     (seed_we_i),
    .load_val_i (seed_wdata_i),
    .next_o     (lfsr_d),
    .lockup_o   (lockup_d)
  );

  // Enable sequencing, LFSR step enable and counter-reset causes
  always_comb begin
    state_d  = state_q;
    cntrst_d = seed_we_i;
    step_en  = 1'b0;
    freq_d   = cpuctrl_we_i ? wr_freq : freq_q;
    unique case (state_q)
      OFF: begin
        if (cpuctrl_we_i && wr_en) begin
          state_d  = ARM;
          cntrst_d = 1'b1;
        end
      end
      ARM: begin
        step_en = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        step_en = shift_i;
        if (cpuctrl_we_i) begin
          if (!wr_en) begin
            state_d  = OFF;
            cntrst_d = 1'b1;
          end
          if (wr_freq != freq_q) begin
            cntrst_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = OFF;
      end
    endcase
  end

  // State, LFSR and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= OFF;
      lfsr_q   <= LFSR_SEED;
      freq_q   <= 4'h0;
      rnd_q    <= 1'b0;
      cntrst_q <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      freq_q   <= freq_d;
      rnd_q    <= (state_d == RUN);
      cntrst_q <= cntrst_d;
      lockup_q <= lockup_d;
    end
  end

`ifdef CV32E40S_LFSR_LOCKUP_CNT_EN
  logic [7:0] cnt_q;

  // Saturating lockup count, cleared by a nonzero seed write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'h00;
    end else if (lockup_d) begin
      if (cnt_q != 8'hFF) begin
        cnt_q <= cnt_q + 8'h01;
      end
    end else if (seed_we_i) begin
      cnt_q <= 8'h00;
    end
  end

  assign lockup_cnt_o = cnt_q;
`endif

  assign lfsr_o         = lfsr_q;
  assign rnddummy_o     = rnd_q;
  assign rnddummyfreq_o = freq_q;
  assign cntrst_o       = cntrst_q;
  assign lockup_o       = lockup_q;

endmodule
